// File: rtl/score_mux_pkg.sv
// Shared constants for the score_mux slice: scan digit indices, anode patterns, BCD limit.
// Optional feature macro used by the top level: SCORE_BLANK_EN (leading-zero blanking).
package score_mux_pkg;

    typedef enum logic [1:0] {
        DIG_P1_TENS  = 2'd0,
        DIG_P1_UNITS = 2'd1,
        DIG_P2_TENS  = 2'd2,
        DIG_P2_UNITS = 2'd3
    } digit_e;

    localparam logic [3:0] AN_P1_TENS  = 4'b0111;
    localparam logic [3:0] AN_P1_UNITS = 4'b1011;
    localparam logic [3:0] AN_P2_TENS  = 4'b1101;
    localparam logic [3:0] AN_P2_UNITS = 4'b1110;
    localparam logic [3:0] AN_OFF      = 4'b1111;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/score_mux_bcd2_counter.sv
// Two-digit saturating BCD counter (00..99) with synchronous clear; also exports the binary value.
module bcd2_counter
    import score_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value
);

    logic [3:0] r_tens;
    logic [3:0] r_units;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (inc) begin
            if (r_units != BCD_MAX) begin
                r_units <= r_units + 4'd1;
            end else if (r_tens != BCD_MAX) begin
                r_units <= '0;
                r_tens  <= r_tens + 4'd1;
            end
            // at 99 both nibbles hold
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign value = 7'(r_tens) * 7'd10 + 7'(r_units);

endmodule

// File: rtl/score_mux.sv
// Pong score keeper: two BCD score counters, game-over/winner latch, 4-digit multiplexed display scan.
// Optional macro SCORE_BLANK_EN: dark tens digit while that player's tens nibble is 0.
module score_mux
    import score_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned WIN_SCORE   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       clr_scores,
    output logic [3:0] bcd,
    output logic [3:0] an_n,
    output logic       game_over,
    output logic       winner
);

    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  WIN_VAL    = 7'(WIN_SCORE);

    logic       w_accept;
    logic [3:0] w_p1_tens, w_p1_units, w_p2_tens, w_p2_units;
    logic [6:0] w_p1_value, w_p2_value;
    logic       w_p1_win, w_p2_win;
    logic       w_tick;
    logic [3:0] w_bcd_next, w_an_next;
    digit_e     w_idx_next;

    logic [15:0] r_presc;
    digit_e      r_idx;
    logic [3:0]  r_bcd;
    logic [3:0]  r_an_n;
    logic        r_game_over;
    logic        r_winner;

    assign w_accept = !r_game_over && !clr_scores;

    bcd2_counter u_p1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (p1_point && w_accept),
        .clr   (clr_scores),
        .tens  (w_p1_tens),
        .units (w_p1_units),
        .value (w_p1_value)
    );

    bcd2_counter u_p2 (
        .clk   (clk),
        .rst   (rst),
        .inc   (p2_point && w_accept),
        .clr   (clr_scores),
        .tens  (w_p2_tens),
        .units (w_p2_units),
        .value (w_p2_value)
    );

    assign w_p1_win = (w_p1_value >= WIN_VAL);
    assign w_p2_win = (w_p2_value >= WIN_VAL);

    // Player 1 wins ties, so winner is set only when player 1 has not reached the threshold.
    always_ff @(posedge clk) begin
        if (rst || clr_scores) begin
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else if (!r_game_over && (w_p1_win || w_p2_win)) begin
            r_game_over <= 1'b1;
            r_winner    <= !w_p1_win;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= DIG_P2_UNITS;
            r_bcd   <= '0;
            r_an_n  <= AN_OFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 16'd1;
            r_idx   <= w_idx_next;
            if (w_tick) begin
                r_bcd  <= w_bcd_next;
                r_an_n <= w_an_next;
            end
        end
    end

    always_comb begin
        w_idx_next = r_idx;
        if (w_tick) begin
            case (r_idx)
                DIG_P1_TENS:  w_idx_next = DIG_P1_UNITS;
                DIG_P1_UNITS: w_idx_next = DIG_P2_TENS;
                DIG_P2_TENS:  w_idx_next = DIG_P2_UNITS;
                default:      w_idx_next = DIG_P1_TENS;
            endcase
        end
    end

    always_comb begin
        w_bcd_next = '0;
        w_an_next  = AN_OFF;
        case (w_idx_next)
            DIG_P1_TENS:  begin w_bcd_next = w_p1_tens;  w_an_next = AN_P1_TENS;  end
            DIG_P1_UNITS: begin w_bcd_next = w_p1_units; w_an_next = AN_P1_UNITS; end
            DIG_P2_TENS:  begin w_bcd_next = w_p2_tens;  w_an_next = AN_P2_TENS;  end
            default:      begin w_bcd_next = w_p2_units; w_an_next = AN_P2_UNITS; end
        endcase
`ifdef SCORE_BLANK_EN
        if ((w_idx_next == DIG_P1_TENS && w_p1_tens == 4'd0) ||
            (w_idx_next == DIG_P2_TENS && w_p2_tens == 4'd0)) begin
            w_an_next = AN_OFF;
        end
`endif
    end

    assign bcd       = r_bcd;
    assign an_n      = r_an_n;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_score_mux.sv
// Self-checking bench for score_mux: integer-score reference model checked every cycle, plus directed literals.
module tb_score_mux;

    localparam int DIV = 4;
    localparam int WIN = 11;
`ifdef SCORE_BLANK_EN
    localparam logic [3:0] AN_D3_ZERO = 4'b1111;
`else
    localparam logic [3:0] AN_D3_ZERO = 4'b0111;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1 = 1'b0, p2 = 1'b0, clr = 1'b0;
    logic [3:0] bcd, an_n;
    logic       go, winner;

    logic       p1b = 1'b0;
    logic [3:0] bcd_b, an_b;
    logic       go_b, win_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    score_mux #(.REFRESH_DIV(DIV), .WIN_SCORE(WIN)) dut (
        .clk(clk), .rst(rst), .p1_point(p1), .p2_point(p2), .clr_scores(clr),
        .bcd(bcd), .an_n(an_n), .game_over(go), .winner(winner)
    );

    score_mux #(.REFRESH_DIV(DIV), .WIN_SCORE(99)) dut_sat (
        .clk(clk), .rst(rst), .p1_point(p1b), .p2_point(1'b0), .clr_scores(1'b0),
        .bcd(bcd_b), .an_n(an_b), .game_over(go_b), .winner(win_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: scores as integers, display slot derived from cycles since reset.
    int         s1, s2, t;
    bit         m_go, m_win, model_valid = 1'b0;
    logic [3:0] m_bcd, m_an;

    always @(posedge clk) begin : model
        int idx, v;
        bit g1, g2, acc;
        if (rst) begin
            s1 = 0; s2 = 0; t = 0; m_go = 0; m_win = 0;
            m_bcd = 4'h0; m_an = 4'b1111; model_valid = 1'b1;
        end else begin
            if (t % DIV == DIV - 1) begin
                idx = (t / DIV) % 4;
                case (idx)
                    0:       v = s1 / 10;
                    1:       v = s1 % 10;
                    2:       v = s2 / 10;
                    default: v = s2 % 10;
                endcase
                m_bcd = 4'(v);
                m_an  = 4'b1111 ^ (4'b1000 >> idx);
`ifdef SCORE_BLANK_EN
                if ((idx == 0 || idx == 2) && v == 0) m_an = 4'b1111;
`endif
            end
            t++;
            g1  = (s1 >= WIN);
            g2  = (s2 >= WIN);
            acc = !m_go && !clr;
            if (clr) begin
                s1 = 0; s2 = 0; m_go = 0; m_win = 0;
            end else begin
                if (!m_go && (g1 || g2)) begin
                    m_go  = 1;
                    m_win = !g1;
                end
                if (acc && p1) s1 = (s1 < 99) ? s1 + 1 : 99;
                if (acc && p2) s2 = (s2 < 99) ? s2 + 1 : 99;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("bcd", int'(bcd), int'(m_bcd));
            check("an_n", int'(an_n), int'(m_an));
            check("game_over", int'(go), int'(m_go));
            check("winner", int'(winner), int'(m_win));
            check("sat_bcd_le9", int'(bcd_b <= 4'd9), 1);
        end
    end

    task automatic wait_an(input string name, input logic [3:0] pat, input bit sat);
        int k = 0;
        while (((sat ? an_b : an_n) != pat) && k < 64) begin
            @(negedge clk);
            k++;
        end
        check({name, "_wait"}, int'(k < 64), 1);
    endtask

    task automatic wait_leave(input string name, input logic [3:0] pat, input bit sat);
        int k = 0;
        while (((sat ? an_b : an_n) == pat) && k < 64) begin
            @(negedge clk);
            k++;
        end
        check({name, "_leave"}, int'(k < 64), 1);
    endtask

    // Skip any slot that may have been loaded before the latest score change.
    task automatic fresh_slot(input string name, input logic [3:0] pat, input bit sat);
        wait_leave(name, pat, sat);
        wait_an(name, pat, sat);
    endtask

    task automatic pulse(input bit a, input bit b, input bit c);
        p1 = a; p2 = b; clr = c;
        @(negedge clk);
        p1 = 0; p2 = 0; clr = 0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(negedge clk);
        check("rst_an_n", int'(an_n), 15);
        check("rst_bcd", int'(bcd), 0);
        check("rst_go", int'(go), 0);
        rst = 0;
        repeat (3) @(negedge clk);
        check("dark_before_tick", int'(an_n), 15);
        @(negedge clk);
        check("first_tick_an", int'(an_n), int'(AN_D3_ZERO));
        check("first_tick_bcd", int'(bcd), 0);

        for (int i = 0; i < 10; i++) pulse(1, 0, 0);
        fresh_slot("carry_d3", 4'b0111, 0);
        check("carry_tens", int'(bcd), 1);
        fresh_slot("carry_d2", 4'b1011, 0);
        check("carry_units", int'(bcd), 0);

        for (int i = 0; i < 10; i++) pulse(0, 1, 0);
        p2 = 1;
        @(negedge clk);
        p2 = 0;
        check("go_edge1", int'(go), 0);
        @(negedge clk);
        check("go_edge2", int'(go), 1);
        check("winner_p2", int'(winner), 1);

        pulse(1, 0, 0);
        fresh_slot("lock_d3", 4'b0111, 0);
        check("lock_tens", int'(bcd), 1);
        fresh_slot("lock_d2", 4'b1011, 0);
        check("lock_units", int'(bcd), 0);

        pulse(1, 0, 1);
        check("clr_go", int'(go), 0);
        fresh_slot("clr_d2", 4'b1011, 0);
        check("clr_p1_units", int'(bcd), 0);
        fresh_slot("clr_d0", 4'b1110, 0);
        check("clr_p2_units", int'(bcd), 0);

        pulse(1, 1, 0);
        fresh_slot("both_d2", 4'b1011, 0);
        check("both_p1_units", int'(bcd), 1);
        fresh_slot("both_d0", 4'b1110, 0);
        check("both_p2_units", int'(bcd), 1);

        for (int i = 0; i < 10; i++) pulse(1, 1, 0);
        check("tie_go", int'(go), 1);
        check("tie_winner_p1", int'(winner), 0);

        pulse(0, 0, 1);
        for (int i = 0; i < 5; i++) pulse(1, 0, 0);
        wait_an("blank_pre", 4'b1110, 0);
        wait_leave("blank_d3", 4'b1110, 0);
        check("blank_an_n", int'(an_n), int'(AN_D3_ZERO));
        check("blank_bcd", int'(bcd), 0);

        for (int i = 0; i < 120; i++) begin
            p1b = 1;
            @(negedge clk);
            p1b = 0;
            @(negedge clk);
        end
        fresh_slot("sat_d3", 4'b0111, 1);
        check("sat_tens", int'(bcd_b), 9);
        fresh_slot("sat_d2", 4'b1011, 1);
        check("sat_units", int'(bcd_b), 9);
        check("sat_go", int'(go_b), 1);
        check("sat_winner", int'(win_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
